// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain with valid/ready handshake, flush and occupancy.
// SKID=0 uses single-entry stages; SKID=1 uses two-entry stages with a registered ready.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SKID  = 0,
    parameter int CNT_W = $clog2(DEPTH*(1+SKID)+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] occupancy
);
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0]            src_vld;
    logic [DEPTH-1:0][WIDTH-1:0] src_dat;
    logic                        accept;
    logic                        emit;

    // Source of stage k is stage k-1; stage 0 is fed by the producer.
    always_comb begin
        src_vld    = '0;
        src_dat    = '0;
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_vld[k] = vld[k-1];
            src_dat[k] = dat[k-1];
        end
    end

    if (SKID == 0) begin : g_plain
        logic [DEPTH-1:0] rdy;

        // A stage is ready if it is empty or everything ahead of it moves.
        always_comb begin
            logic r;
            rdy = '0;
            r   = out_ready;
            for (int k = DEPTH-1; k >= 0; k--) begin
                r      = !vld[k] || r;
                rdy[k] = r;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
                dat <= '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (flush)
                        vld[k] <= 1'b0;
                    else if (rdy[k])
                        vld[k] <= src_vld[k];
                    if (rdy[k] && src_vld[k])
                        dat[k] <= src_dat[k];
                end
            end
        end

        assign in_ready = rdy[0];
    end else begin : g_skid
        logic [DEPTH-1:0]            svld;
        logic [DEPTH-1:0][WIDTH-1:0] sdat;
        logic [DEPTH:0]              free_ext;
        logic [DEPTH-1:0]            dn_rdy;
        logic [DEPTH-1:0]            up_fire;
        logic [DEPTH-1:0]            drain;

        // Downstream readiness comes from registered skid flags only.
        assign free_ext = {out_ready, ~svld};
        assign dn_rdy   = free_ext[DEPTH:1];
        assign up_fire  = src_vld & ~svld;
        assign drain    = ~vld | dn_rdy;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld  <= '0;
                svld <= '0;
                dat  <= '0;
                sdat <= '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (flush) begin
                        vld[k]  <= 1'b0;
                        svld[k] <= 1'b0;
                    end else if (drain[k]) begin
                        // Main is free: the older skid entry refills it before new input.
                        if (svld[k]) begin
                            vld[k]  <= 1'b1;
                            dat[k]  <= sdat[k];
                            svld[k] <= 1'b0;
                        end else begin
                            vld[k] <= up_fire[k];
                            if (up_fire[k])
                                dat[k] <= src_dat[k];
                        end
                    end else if (up_fire[k]) begin
                        svld[k] <= 1'b1;
                        sdat[k] <= src_dat[k];
                    end
                end
            end
        end

        assign in_ready = !svld[0];
    end

    assign out_valid   = vld[DEPTH-1];
    assign out_data    = dat[DEPTH-1];
    assign stage_valid = vld;
    assign accept      = in_valid & in_ready;
    assign emit        = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occupancy <= '0;
        else if (flush)
            occupancy <= '0;
        else if (accept && !emit)
            occupancy <= occupancy + CNT_W'(1);
        else if (!accept && emit)
            occupancy <= occupancy - CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a plain instance (DEPTH=3) and a skid instance (DEPTH=2)
// share one stimulus stream; each is tracked by a queue-based reference model.
module tb_pipe_stage_chain;
    localparam int DA = 3;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        ir_a, ov_a, ir_b, ov_b;
    logic [31:0] od_a, od_b;
    logic [2:0]  sv_a;
    logic [1:0]  sv_b;
    logic [1:0]  occ_a;
    logic [2:0]  occ_b;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(DA), .SKID(0)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .stage_valid(sv_a), .occupancy(occ_a)
    );

    pipe_stage_chain #(.WIDTH(32), .DEPTH(DB), .SKID(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .stage_valid(sv_b), .occupancy(occ_b)
    );

    typedef struct {
        logic [31:0] data;
        int          t;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        int          occ;
        logic        ir;
    } vec_t;

    ent_t qa[$];
    ent_t qb[$];
    vec_t tbl[17];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   emits_b = 0;
    logic last_acc_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A beat accepted in cycle t is at the head by t+D: the oldest entry never waits.
    function automatic logic head_out(input int n, input int t, input int d);
        return (n > 0) && (cyc - t >= d);
    endfunction

    task automatic settle();
        int   n;
        int   t;
        logic ev;
        #1;
        n  = qa.size();
        t  = (n > 0) ? qa[0].t : 0;
        ev = head_out(n, t, DA);
        chk("a_out_valid", ov_a, ev);
        if (ev) chk("a_out_data", od_a, qa[0].data);
        chk("a_occupancy", occ_a, n);
        chk("a_in_ready", ir_a, !(n == DA && !out_ready));
        chk("a_stage_count", $countones(sv_a), n);
        n  = qb.size();
        t  = (n > 0) ? qb[0].t : 0;
        ev = head_out(n, t, DB);
        chk("b_out_valid", ov_b, ev);
        if (ev) chk("b_out_data", od_b, qb[0].data);
        chk("b_occupancy", occ_b, n);
        if (n == 2*DB) chk("b_in_ready_full", ir_b, 1'b0);
        if (n == 0) begin
            chk("b_in_ready_empty", ir_b, 1'b1);
            chk("b_stage_empty", sv_b, 2'b00);
        end
    endtask

    task automatic advance();
        logic acc_a, acc_b, em_a, em_b;
        ent_t e;
        acc_a = in_valid & ir_a;
        acc_b = in_valid & ir_b;
        em_a  = out_ready && head_out(qa.size(), (qa.size() > 0) ? qa[0].t : 0, DA);
        em_b  = out_ready && head_out(qb.size(), (qb.size() > 0) ? qb[0].t : 0, DB);
        @(posedge clk);
        if (em_a) qa.delete(0);
        if (em_b) begin
            qb.delete(0);
            emits_b++;
        end
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            e.data = in_data;
            e.t    = cyc;
            if (acc_a) qa.push_back(e);
            if (acc_b) qb.push_back(e);
        end
        last_acc_b = acc_b;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        int          nb;
        int          max_occ;
        logic        saw_stall;
        logic        ir0;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        chk("rst_a_out_valid", ov_a, 1'b0);
        chk("rst_a_occupancy", occ_a, 0);
        chk("rst_a_in_ready", ir_a, 1'b1);
        chk("rst_a_stage_valid", sv_a, 3'b000);
        chk("rst_a_out_data", od_a, 32'h0);
        chk("rst_b_out_valid", ov_b, 1'b0);
        chk("rst_b_occupancy", occ_b, 0);
        chk("rst_b_in_ready", ir_b, 1'b1);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // {iv, data, out_ready, exp ov, exp od, exp occ, exp in_ready} for the DEPTH=3 chain
        tbl[0]  = '{1'b1, 32'h1,  1'b1, 1'b0, 32'h0, 0, 1'b1};
        tbl[1]  = '{1'b1, 32'h2,  1'b1, 1'b0, 32'h0, 1, 1'b1};
        tbl[2]  = '{1'b1, 32'h3,  1'b1, 1'b0, 32'h0, 2, 1'b1};
        tbl[3]  = '{1'b1, 32'h4,  1'b1, 1'b1, 32'h1, 3, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h2, 3, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h3, 2, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4, 1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 0, 1'b1};
        tbl[8]  = '{1'b1, 32'hA,  1'b0, 1'b0, 32'h0, 0, 1'b1};
        tbl[9]  = '{1'b1, 32'hB,  1'b0, 1'b0, 32'h0, 1, 1'b1};
        tbl[10] = '{1'b1, 32'hC,  1'b0, 1'b0, 32'h0, 2, 1'b1};
        tbl[11] = '{1'b1, 32'hEE, 1'b0, 1'b1, 32'hA, 3, 1'b0};
        tbl[12] = '{1'b1, 32'hEE, 1'b0, 1'b1, 32'hA, 3, 1'b0};
        tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA, 3, 1'b1};
        tbl[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hB, 2, 1'b1};
        tbl[15] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hC, 1, 1'b1};
        tbl[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            settle();
            chk("tbl_out_valid", ov_a, tbl[i].ov);
            if (tbl[i].ov) chk("tbl_out_data", od_a, tbl[i].od);
            chk("tbl_occupancy", occ_a, tbl[i].occ);
            chk("tbl_in_ready", ir_a, tbl[i].ir);
            advance();
        end
        out_ready = 1'b1;
        idle(3);

        // Flush with three entries held, a concurrent accept and a concurrent emit.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(i);
            settle();
            advance();
        end
        in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1; flush = 1'b1;
        settle();
        chk("flush_emit_data", od_a, 32'h100);
        advance();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("flush_occupancy", occ_a, 0);
        chk("flush_stage_valid", sv_a, 3'b000);
        chk("flush_out_valid", ov_a, 1'b0);
        chk("flush_in_ready", ir_a, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("flush_no_dead", ov_a, 1'b0);
            advance();
        end

        // Bubble collapse: two beats separated by idle cycles pack at the output end.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; settle(); advance();
        idle(2);
        in_valid = 1'b1; in_data = 32'h6; settle(); advance();
        idle(1);
        settle();
        chk("bubble_stage_valid", sv_a, 3'b110);
        chk("bubble_head", od_a, 32'h5);
        advance();
        out_ready = 1'b1;
        idle(4);

        // Asynchronous reset between edges with two entries held.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h70 + 32'(i);
            settle();
            advance();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", ov_a, 1'b0);
        chk("arst_occupancy", occ_a, 0);
        chk("arst_in_ready", ir_a, 1'b1);
        chk("arst_stage_valid", sv_a, 3'b000);
        chk("arst_b_occupancy", occ_b, 0);
        chk("arst_b_in_ready", ir_b, 1'b1);
        qa.delete(); qb.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h7;
        settle(); advance();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            settle();
            if (i == 3) begin
                chk("arst_first_valid", ov_a, 1'b1);
                chk("arst_first_data", od_a, 32'h7);
            end else begin
                chk("arst_latency", ov_a, 1'b0);
            end
            advance();
        end
        idle(3);

        // Skid chain: eight beats with the consumer stalled for cycles 3-6.
        nb = 0; emits_b = 0; max_occ = 0; saw_stall = 1'b0;
        for (int c = 0; c < 40 && emits_b < 8; c++) begin
            in_valid  = (nb < 8);
            in_data   = 32'(nb + 1);
            out_ready = !(c >= 3 && c <= 6);
            settle();
            if (int'(occ_b) > max_occ) max_occ = int'(occ_b);
            if (!ir_b) saw_stall = 1'b1;
            ir0 = ir_b;
            out_ready = !out_ready; #1;
            chk("skid_ready_indep", ir_b, ir0);
            out_ready = !out_ready; #1;
            advance();
            if (last_acc_b) nb++;
        end
        chk("skid_emits", emits_b, 8);
        chk("skid_max_occ", max_occ, 4);
        chk("skid_stalled", saw_stall, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        settle();
        chk("skid_drained", occ_b, 0);
        advance();
        idle(4);

        // Randomised traffic with bursts of backpressure and rare flushes.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = $urandom;
            out_ready = (c % 64 < 40) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
            flush     = ($urandom_range(59) == 0);
            settle();
            advance();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
